// File: rtl/card_deal_pkg.sv
// Shared constants for the card deal controller and deck datapath.
// Holds FSM states, datapath request states, requester IDs and defaults.
package card_deal_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SEND,
    S_WAIT,
    S_CHECK,
    S_DELIVER,
    S_EMPTY,
    S_ERROR
  } state_t;

  localparam logic IDLE = 1'b0;
  localparam logic SEND = 1'b1;

  localparam logic REQ_PLAYER = 1'b0;
  localparam logic REQ_DEALER = 1'b1;

  localparam int DECK_SIZE_DFLT  = 52;
  localparam int DP_LATENCY_DFLT = 2;
  localparam int MAX_RETRY_DFLT  = 3;

endpackage

// File: rtl/card_deal_arbiter_rr.sv
// card_rr_arbiter: 2-way round-robin grant (player/dealer).
// Ports: clk, rst_n, req_player, req_dealer, adv (flip pointer), gnt (ID).
module card_rr_arbiter
  import card_deal_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic req_player,
  input  logic req_dealer,
  input  logic adv,
  output logic gnt
);

  logic ptr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= REQ_PLAYER;
    end else if (adv) begin
      ptr <= ~ptr;
    end
  end

  // A lone requester always wins; the pointer only breaks ties.
  always_comb begin
    gnt = ptr;
    if (req_player && !req_dealer) begin
      gnt = REQ_PLAYER;
    end else if (req_dealer && !req_player) begin
      gnt = REQ_DEALER;
    end
  end

endmodule

// File: rtl/card_deal_arbiter.sv
// Deals cards from the deck datapath to player/dealer, with retry on zero cards.
// Ports: clk_ctrl_i, rst_ctrl_i (async low), req_player_i, req_dealer_i, card_dp_i;
// req_card_state_o, card_o, ack_player_o, ack_dealer_o, cards_left_o,
// deck_empty_o, err_o. DEAL_STATS_EN adds player_cnt_o, dealer_cnt_o,
// retry_total_o.
module card_deal_arbiter
  import card_deal_pkg::*;
#(
  parameter int DECK_SIZE  = DECK_SIZE_DFLT,
  parameter int DP_LATENCY = DP_LATENCY_DFLT,
  parameter int MAX_RETRY  = MAX_RETRY_DFLT
) (
  input  logic       clk_ctrl_i,
  input  logic       rst_ctrl_i,
  input  logic       req_player_i,
  input  logic       req_dealer_i,
  input  logic [7:0] card_dp_i,
  output logic       req_card_state_o,
  output logic [7:0] card_o,
  output logic       ack_player_o,
  output logic       ack_dealer_o,
  output logic [5:0] cards_left_o,
  output logic       deck_empty_o,
`ifdef DEAL_STATS_EN
  output logic [5:0] player_cnt_o,
  output logic [5:0] dealer_cnt_o,
  output logic [7:0] retry_total_o,
`endif
  output logic       err_o
);

  localparam logic [2:0] LAT_INIT = 3'(DP_LATENCY - 1);
  localparam logic [2:0] RTY_MAX  = 3'(MAX_RETRY);
  localparam logic [5:0] DECK_N   = 6'(DECK_SIZE);

  state_t     state;
  logic       gnt_q;
  logic       arb_gnt;
  logic [2:0] retry_q;
  logic [2:0] retry_nxt;
  logic [2:0] lat_q;
  logic       any_req;

  assign any_req   = req_player_i | req_dealer_i;
  assign retry_nxt = (retry_q == 3'd7) ? retry_q : retry_q + 3'd1;

  card_rr_arbiter u_arb (
    .clk        (clk_ctrl_i),
    .rst_n      (rst_ctrl_i),
    .req_player (req_player_i),
    .req_dealer (req_dealer_i),
    .adv        (state == S_DELIVER),
    .gnt        (arb_gnt)
  );

  // Ack, card and the deck count all update together on the way into
  // DELIVER, so they are visible in the same cycle as the ack pulse.
  always_ff @(posedge clk_ctrl_i or negedge rst_ctrl_i) begin
    if (!rst_ctrl_i) begin
      state            <= S_IDLE;
      req_card_state_o <= IDLE;
      card_o           <= 8'd0;
      ack_player_o     <= 1'b0;
      ack_dealer_o     <= 1'b0;
      cards_left_o     <= DECK_N;
      deck_empty_o     <= 1'b0;
      err_o            <= 1'b0;
      gnt_q            <= REQ_PLAYER;
      retry_q          <= 3'd0;
      lat_q            <= 3'd0;
    end else begin
      case (state)
        S_IDLE: begin
          if (any_req && !deck_empty_o) begin
            gnt_q            <= arb_gnt;
            req_card_state_o <= SEND;
            state            <= S_SEND;
          end
        end
        S_SEND: begin
          req_card_state_o <= IDLE;
          lat_q            <= LAT_INIT;
          state            <= S_WAIT;
        end
        S_WAIT: begin
          if (lat_q == 3'd0) begin
            state <= S_CHECK;
          end else begin
            lat_q <= lat_q - 3'd1;
          end
        end
        S_CHECK: begin
          if (card_dp_i == 8'd0) begin
            retry_q <= retry_nxt;
            if (retry_nxt > RTY_MAX) begin
              err_o <= 1'b1;
              state <= S_ERROR;
            end else begin
              req_card_state_o <= SEND;
              state            <= S_SEND;
            end
          end else begin
            card_o       <= card_dp_i;
            retry_q      <= 3'd0;
            ack_player_o <= (gnt_q == REQ_PLAYER);
            ack_dealer_o <= (gnt_q == REQ_DEALER);
            if (cards_left_o != 6'd0) begin
              cards_left_o <= cards_left_o - 6'd1;
            end
            if (cards_left_o == 6'd1) begin
              deck_empty_o <= 1'b1;
            end
            state <= S_DELIVER;
          end
        end
        S_DELIVER: begin
          ack_player_o <= 1'b0;
          ack_dealer_o <= 1'b0;
          state        <= deck_empty_o ? S_EMPTY : S_IDLE;
        end
        S_EMPTY: begin
          state <= S_EMPTY;
        end
        S_ERROR: begin
          state <= S_ERROR;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

`ifdef DEAL_STATS_EN
  logic reissue;
  assign reissue = (state == S_CHECK) && (card_dp_i == 8'd0)
                   && !(retry_nxt > RTY_MAX);

  always_ff @(posedge clk_ctrl_i or negedge rst_ctrl_i) begin
    if (!rst_ctrl_i) begin
      player_cnt_o  <= 6'd0;
      dealer_cnt_o  <= 6'd0;
      retry_total_o <= 8'd0;
    end else begin
      if (ack_player_o && player_cnt_o != 6'd63) begin
        player_cnt_o <= player_cnt_o + 6'd1;
      end
      if (ack_dealer_o && dealer_cnt_o != 6'd63) begin
        dealer_cnt_o <= dealer_cnt_o + 6'd1;
      end
      if (reissue && retry_total_o != 8'd255) begin
        retry_total_o <= retry_total_o + 8'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_card_deal_arbiter.sv
// Directed testbench for card_deal_arbiter.
// Drives requests and a scripted card source; checks timing and flags.
module tb_card_deal_arbiter;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       req_p = 1'b0;
  logic       req_d = 1'b0;
  logic [7:0] card_dp = 8'd0;
  logic       req_state;
  logic [7:0] card;
  logic       ack_p;
  logic       ack_d;
  logic [5:0] left;
  logic       empty;
  logic       err;
`ifdef DEAL_STATS_EN
  logic [5:0] pcnt;
  logic [5:0] dcnt;
  logic [7:0] rtot;
`endif

  int errors = 0;
  int checks = 0;

  logic [7:0] card_q[$];
  logic [7:0] card_def = 8'd0;

  card_deal_arbiter dut (
    .clk_ctrl_i       (clk),
    .rst_ctrl_i       (rst_n),
    .req_player_i     (req_p),
    .req_dealer_i     (req_d),
    .card_dp_i        (card_dp),
    .req_card_state_o (req_state),
    .card_o           (card),
    .ack_player_o     (ack_p),
    .ack_dealer_o     (ack_d),
    .cards_left_o     (left),
    .deck_empty_o     (empty),
`ifdef DEAL_STATS_EN
    .player_cnt_o     (pcnt),
    .dealer_cnt_o     (dcnt),
    .retry_total_o    (rtot),
`endif
    .err_o            (err)
  );

  always #5 clk = ~clk;

  task automatic do_reset;
    req_p = 1'b0;
    req_d = 1'b0;
    card_q.delete();
    card_def = 8'd0;
    card_dp = 8'd0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // Watches up to max cycles (sampled at negedge, cycle 1 = the cycle in
  // which the request is first sampled). Feeds the next card on each SEND.
  // Returns one cycle after the ack, just past the rising edge.
  task automatic observe(
    input  int         max,
    output int         ack_at,
    output logic       who,
    output int         sends,
    output int         first_send,
    output int         both,
    output logic [5:0] left_at,
    output logic       empty_at
  );
    ack_at = -1;
    who = 1'b0;
    sends = 0;
    first_send = -1;
    both = 0;
    left_at = 6'd0;
    empty_at = 1'b0;
    for (int i = 1; i <= max; i++) begin
      @(negedge clk);
      if (req_state) begin
        sends++;
        if (first_send < 0) first_send = i;
        card_dp = (card_q.size() > 0) ? card_q.pop_front() : card_def;
      end
      if (ack_p && ack_d) both++;
      if (ack_p || ack_d) begin
        ack_at = i;
        who = ack_d;
        left_at = left;
        empty_at = empty;
        break;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    do_reset();
    checks++;
    if (req_state !== 1'b0) begin
      errors++; $display("FAIL rst_req_state got %0b exp 0", req_state);
    end
    checks++;
    if (card !== 8'h00) begin
      errors++; $display("FAIL rst_card got %0h exp 00", card);
    end
    checks++;
    if ({ack_p, ack_d} !== 2'b00) begin
      errors++; $display("FAIL rst_acks got %0b exp 00", {ack_p, ack_d});
    end
    checks++;
    if (left !== 6'd52) begin
      errors++; $display("FAIL rst_left got %0d exp 52", left);
    end
    checks++;
    if (empty !== 1'b0) begin
      errors++; $display("FAIL rst_empty got %0b exp 0", empty);
    end
    checks++;
    if (err !== 1'b0) begin
      errors++; $display("FAIL rst_err got %0b exp 0", err);
    end
  endtask

  task automatic test_single;
    int a, s, fs, b;
    logic w, e;
    logic [5:0] l;
    card_def = 8'h15;
    req_p = 1'b1;
    observe(20, a, w, s, fs, b, l, e);
    req_p = 1'b0;
    checks++;
    if (fs !== 2) begin
      errors++; $display("FAIL single_send_cycle got %0d exp 2", fs);
    end
    checks++;
    if (s !== 1) begin
      errors++; $display("FAIL single_send_count got %0d exp 1", s);
    end
    checks++;
    if (a !== 6) begin
      errors++; $display("FAIL single_ack_cycle got %0d exp 6", a);
    end
    checks++;
    if (w !== 1'b0) begin
      errors++; $display("FAIL single_who got %0b exp 0", w);
    end
    checks++;
    if (card !== 8'h15) begin
      errors++; $display("FAIL single_card got %0h exp 15", card);
    end
    checks++;
    if (l !== 6'd51) begin
      errors++; $display("FAIL single_left got %0d exp 51", l);
    end
  endtask

  task automatic test_contention;
    int a, s, fs, b;
    int both_tot;
    logic w, e;
    logic [5:0] l;
    logic exp_w[4];
    exp_w = '{1'b0, 1'b1, 1'b0, 1'b1};
    both_tot = 0;
    do_reset();
    card_def = 8'h2a;
    req_p = 1'b1;
    req_d = 1'b1;
    for (int k = 0; k < 4; k++) begin
      observe(20, a, w, s, fs, b, l, e);
      both_tot += b;
      checks++;
      if (w !== exp_w[k] || a !== 6) begin
        errors++;
        $display("FAIL contention_%0d who=%0b at=%0d exp who=%0b at=6",
                 k, w, a, exp_w[k]);
      end
    end
    req_p = 1'b0;
    req_d = 1'b0;
    checks++;
    if (both_tot !== 0) begin
      errors++; $display("FAIL contention_double_ack got %0d exp 0", both_tot);
    end
    checks++;
    if (left !== 6'd48) begin
      errors++; $display("FAIL contention_left got %0d exp 48", left);
    end
  endtask

  task automatic test_zero_card;
    int a, s, fs, b;
    logic w, e;
    logic [5:0] l;
    card_q.push_back(8'h00);
    card_q.push_back(8'h07);
    req_d = 1'b1;
    observe(40, a, w, s, fs, b, l, e);
    req_d = 1'b0;
    checks++;
    if (s !== 2) begin
      errors++; $display("FAIL zero_sends got %0d exp 2", s);
    end
    checks++;
    if (a !== 10) begin
      errors++; $display("FAIL zero_ack_cycle got %0d exp 10", a);
    end
    checks++;
    if (w !== 1'b1) begin
      errors++; $display("FAIL zero_who got %0b exp 1", w);
    end
    checks++;
    if (card !== 8'h07) begin
      errors++; $display("FAIL zero_card got %0h exp 07", card);
    end
    checks++;
    if (l !== 6'd47) begin
      errors++; $display("FAIL zero_left got %0d exp 47", l);
    end
  endtask

  task automatic test_retry_overflow;
    int a, s, fs, b;
    logic w, e;
    logic [5:0] l;
    do_reset();
    card_def = 8'h00;
    req_p = 1'b1;
    observe(60, a, w, s, fs, b, l, e);
    checks++;
    if (s !== 4) begin
      errors++; $display("FAIL retry_sends got %0d exp 4", s);
    end
    checks++;
    if (a !== -1) begin
      errors++; $display("FAIL retry_ack got %0d exp -1", a);
    end
    checks++;
    if (err !== 1'b1) begin
      errors++; $display("FAIL retry_err got %0b exp 1", err);
    end
    req_d = 1'b1;
    observe(20, a, w, s, fs, b, l, e);
    req_p = 1'b0;
    req_d = 1'b0;
    checks++;
    if (s !== 0 || a !== -1) begin
      errors++; $display("FAIL retry_ignore sends=%0d ack=%0d exp 0/-1", s, a);
    end
    checks++;
    if (err !== 1'b1 || left !== 6'd52) begin
      errors++;
      $display("FAIL retry_hold err=%0b left=%0d exp 1/52", err, left);
    end
  endtask

  task automatic test_exhaust;
    int a, s, fs, b;
    int bad;
    logic w, e;
    logic e51;
    logic [5:0] l;
    do_reset();
    card_def = 8'h21;
    bad = 0;
    e51 = 1'b1;
    e = 1'b0;
    l = 6'd63;
    for (int k = 0; k < 52; k++) begin
      req_p = 1'b1;
      observe(20, a, w, s, fs, b, l, e);
      req_p = 1'b0;
      if (a != 6) bad++;
      if (k == 50) e51 = e;
      @(posedge clk);
      #1;
    end
    checks++;
    if (bad !== 0) begin
      errors++; $display("FAIL exhaust_acks missed=%0d exp 0", bad);
    end
    checks++;
    if (e51 !== 1'b0) begin
      errors++; $display("FAIL exhaust_early_empty got %0b exp 0", e51);
    end
    checks++;
    if (e !== 1'b1 || l !== 6'd0) begin
      errors++;
      $display("FAIL exhaust_last_ack empty=%0b left=%0d exp 1/0", e, l);
    end
    req_p = 1'b1;
    observe(30, a, w, s, fs, b, l, e);
    req_p = 1'b0;
    checks++;
    if (s !== 0 || a !== -1) begin
      errors++; $display("FAIL exhaust_53rd sends=%0d ack=%0d exp 0/-1", s, a);
    end
    checks++;
    if (empty !== 1'b1 || left !== 6'd0) begin
      errors++;
      $display("FAIL exhaust_hold empty=%0b left=%0d exp 1/0", empty, left);
    end
  endtask

  task automatic test_reset_wait;
    int a, s, fs, b;
    logic w, e;
    logic [5:0] l;
    do_reset();
    card_def = 8'h44;
    req_p = 1'b1;
    observe(20, a, w, s, fs, b, l, e);
    req_p = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (left !== 6'd51 || card !== 8'h44) begin
      errors++;
      $display("FAIL rwait_pre left=%0d card=%0h exp 51/44", left, card);
    end
    req_p = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (req_state !== 1'b0) begin
      errors++; $display("FAIL rwait_in_wait req_state=%0b exp 0", req_state);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (left !== 6'd52 || card !== 8'h00) begin
      errors++;
      $display("FAIL rwait_async left=%0d card=%0h exp 52/00", left, card);
    end
    req_p = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    card_def = 8'h33;
    req_p = 1'b1;
    observe(20, a, w, s, fs, b, l, e);
    req_p = 1'b0;
    checks++;
    if (a !== 6 || w !== 1'b0) begin
      errors++; $display("FAIL rwait_after ack=%0d who=%0b exp 6/0", a, w);
    end
    checks++;
    if (card !== 8'h33 || l !== 6'd51) begin
      errors++;
      $display("FAIL rwait_card card=%0h left=%0d exp 33/51", card, l);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_contention();
    test_zero_card();
    test_retry_overflow();
    test_exhaust();
    test_reset_wait();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
